// File: rtl/pwm_adc_multichan_processor_if.sv
// Result stream of the multi-channel PWM/ramp ADC post-processor.
// Handshake: the master raises out_valid with every payload field
// (out_channel, out_ave, out_data, out_clamped) stable; a transfer happens on
// a rising clk edge where out_valid && out_ready. While out_valid is high and
// out_ready is low the payload holds still, and out_valid only falls after a
// transfer (or on reset).
interface pwm_adc_multichan_processor_if #(
  parameter int NUM_CH     = 4,
  parameter int INPUT_BITS = 8,
  parameter int OUT_BITS   = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                  out_valid;
  logic                  out_ready;
  logic [CH_W-1:0]       out_channel;
  logic [INPUT_BITS-1:0] out_ave;
  logic [OUT_BITS-1:0]   out_data;
  logic                  out_clamped;

  modport master (
    output out_valid, out_channel, out_ave, out_data, out_clamped,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_channel, out_ave, out_data, out_clamped,
    output out_ready
  );
endinterface

// File: rtl/pwm_adc_multichan_processor.sv
// Multi-channel PWM/ramp ADC post-processor: per-tick accumulation of each
// enabled channel, block average, scale to millivolts, clamp, and emission as
// a channel-tagged valid/ready stream.
module pwm_adc_multichan_processor #(
  parameter int NUM_CH         = 4,
  parameter int INPUT_BITS     = 8,
  parameter int RAMP_BITS      = 8,
  parameter int AVERAGE_POWER  = 4,
  parameter int SCALING_FACTOR = 3400,
  parameter int SHIFT_FACTOR   = 8,
  parameter int CLAMP_MAX      = 3300,
  parameter int OUT_BITS       = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH*INPUT_BITS-1:0] pwm_in,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic                         clear_overrun,
  pwm_adc_multichan_processor_if.master out_if,
  output logic                         overrun,
  output logic                         busy,
  output logic [1:0]                   dbg_state_o
);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ACC_W  = INPUT_BITS + AVERAGE_POWER;
  localparam int PROD_W = INPUT_BITS + $clog2(SCALING_FACTOR + 1);
  localparam logic [CH_W-1:0]      LAST_IDX = CH_W'(NUM_CH - 1);
  localparam logic [RAMP_BITS-1:0] RAMP_MAX = '1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_MULT = 2'd2, S_EMIT = 2'd3} state_t;

  state_t                    state_q, state_d;
  logic [RAMP_BITS-1:0]      ramp_q;
  logic                      tick_q;
  logic [AVERAGE_POWER-1:0]  cnt_q;
  logic [ACC_W-1:0]          acc_q   [NUM_CH];
  logic [ACC_W-1:0]          acc_sum [NUM_CH];
  logic [INPUT_BITS-1:0]     avg_q   [NUM_CH];
  logic [NUM_CH-1:0]         mask_q;
  logic [CH_W-1:0]           idx_q;
  logic [PROD_W-1:0]         prod_q;
  logic [PROD_W-1:0]         sh;
  logic                      overrun_q;
  logic [CH_W-1:0]           out_channel_q;
  logic [INPUT_BITS-1:0]     out_ave_q;
  logic [OUT_BITS-1:0]       out_data_q;
  logic                      out_clamped_q;
  logic                      block_done;
  logic                      load_block;
  logic                      idx_last;

  assign block_done = tick_q && (cnt_q == '1);
  assign load_block = block_done && (state_q == S_IDLE);
  assign idx_last   = (idx_q == LAST_IDX);
  assign sh         = prod_q >> SHIFT_FACTOR;

  // Free-running ramp; tick is registered so it fires the cycle after all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ramp_q <= '0;
      tick_q <= 1'b0;
    end else begin
      ramp_q <= ramp_q + 1'b1;
      tick_q <= (ramp_q == RAMP_MAX);
    end
  end

  // Accumulator inputs: a disabled channel contributes nothing.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      acc_sum[k] = acc_q[k];
      if (ch_enable[k]) acc_sum[k] = acc_q[k] + ACC_W'(pwm_in[k*INPUT_BITS +: INPUT_BITS]);
    end
  end

  // Per-tick accumulation; the completing tick restarts the block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      for (int k = 0; k < NUM_CH; k++) acc_q[k] <= '0;
    end else if (tick_q) begin
      cnt_q <= cnt_q + 1'b1;
      for (int k = 0; k < NUM_CH; k++)
        acc_q[k] <= (block_done || !ch_enable[k]) ? '0 : acc_sum[k];
    end
  end

  // Result bank only loads when the emitter is idle; otherwise flag overrun (set beats clear).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q    <= '0;
      overrun_q <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) avg_q[k] <= '0;
    end else begin
      if (load_block) begin
        mask_q <= ch_enable;
        for (int k = 0; k < NUM_CH; k++) avg_q[k] <= acc_sum[k][ACC_W-1:AVERAGE_POWER];
      end
      if (block_done && (state_q != S_IDLE)) overrun_q <= 1'b1;
      else if (clear_overrun)                overrun_q <= 1'b0;
    end
  end

  // Emit FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Emit FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (load_block) state_d = S_SCAN;
      S_SCAN: begin
        if (mask_q[idx_q]) state_d = S_MULT;
        else if (idx_last) state_d = S_IDLE;
      end
      S_MULT: state_d = S_EMIT;
      S_EMIT: begin
        if (out_if.out_ready) state_d = idx_last ? S_IDLE : S_SCAN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Emit FSM outputs.
  always_comb begin
    out_if.out_valid = (state_q == S_EMIT);
    busy             = (state_q != S_IDLE);
    dbg_state_o      = state_q;
  end

  // Channel index walk, full-width product, and the held output payload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q         <= '0;
      prod_q        <= '0;
      out_channel_q <= '0;
      out_ave_q     <= '0;
      out_data_q    <= '0;
      out_clamped_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: idx_q <= '0;
        S_SCAN: begin
          if (mask_q[idx_q])  prod_q <= PROD_W'(avg_q[idx_q]) * PROD_W'(SCALING_FACTOR);
          else if (!idx_last) idx_q  <= idx_q + 1'b1;
        end
        S_MULT: begin
          out_channel_q <= idx_q;
          out_ave_q     <= avg_q[idx_q];
          if (sh > PROD_W'(CLAMP_MAX)) begin
            out_data_q    <= OUT_BITS'(CLAMP_MAX);
            out_clamped_q <= 1'b1;
          end else begin
            out_data_q    <= OUT_BITS'(sh);
            out_clamped_q <= 1'b0;
          end
        end
        S_EMIT: if (out_if.out_ready && !idx_last) idx_q <= idx_q + 1'b1;
        default: idx_q <= '0;
      endcase
    end
  end

  assign out_if.out_channel = out_channel_q;
  assign out_if.out_ave     = out_ave_q;
  assign out_if.out_data    = out_data_q;
  assign out_if.out_clamped = out_clamped_q;
  assign overrun            = overrun_q;
endmodule

// File: tb/tb_pwm_adc_multichan_processor.sv
// Bench for pwm_adc_multichan_processor with RAMP_BITS=4 (tick every 16 clk,
// block every 256 clk). Stimulus is driven one value per tick slot; expected
// results are pushed when a block's last slot is driven and popped on each
// accepted transfer.
module tb_pwm_adc_multichan_processor;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pwm_in;
  logic [3:0]  ch_enable;
  logic        clear_overrun;
  logic        overrun;
  logic        busy;
  logic [1:0]  dbg_state;

  pwm_adc_multichan_processor_if #(.NUM_CH(4), .INPUT_BITS(8), .OUT_BITS(16)) out_if ();

  pwm_adc_multichan_processor #(
    .NUM_CH(4), .INPUT_BITS(8), .RAMP_BITS(4), .AVERAGE_POWER(4),
    .SCALING_FACTOR(3400), .SHIFT_FACTOR(8), .CLAMP_MAX(3300), .OUT_BITS(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pwm_in(pwm_in),
    .ch_enable(ch_enable),
    .clear_overrun(clear_overrun),
    .out_if(out_if),
    .overrun(overrun),
    .busy(busy),
    .dbg_state_o(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // scoreboard state: {channel[1:0], ave[7:0], data[15:0], clamped}
  logic [26:0] exp_q[$];
  logic [7:0]  blk_vals [16][4];
  int          n_checks = 0;
  int          n_errors = 0;
  int          busy_run = 0;
  int          last_busy_run = 0;
  logic [26:0] obs, snap, exp_v;
  bit          stalled = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic fill_const(input logic [7:0] v0, input logic [7:0] v1,
                            input logic [7:0] v2, input logic [7:0] v3);
    for (int j = 0; j < 16; j++) begin
      blk_vals[j][0] = v0; blk_vals[j][1] = v1;
      blk_vals[j][2] = v2; blk_vals[j][3] = v3;
    end
  endtask

  task automatic fill_random();
    for (int j = 0; j < 16; j++)
      for (int k = 0; k < 4; k++) blk_vals[j][k] = 8'($urandom_range(0, 255));
  endtask

  task automatic push_expected(input logic [3:0] en);
    int sum, ave, d;
    bit clamped;
    for (int k = 0; k < 4; k++) begin
      if (en[k]) begin
        sum = 0;
        for (int j = 0; j < 16; j++) sum += int'(blk_vals[j][k]);
        ave = sum / 16;
        d = (ave * 3400) / 256;
        clamped = (d > 3300);
        if (clamped) d = 3300;
        exp_q.push_back({2'(k), 8'(ave), 16'(d), clamped});
      end
    end
  endtask

  // One block: 16 tick slots of 16 clk each; optional clear pulse on the sampling edge of a slot.
  task automatic run_block(input logic [3:0] en, input bit lost, input int clr_slot);
    for (int j = 0; j < 16; j++) begin
      for (int k = 0; k < 4; k++) pwm_in[k*8 +: 8] = blk_vals[j][k];
      ch_enable = en;
      if (j == 15 && !lost) push_expected(en);
      repeat (8) step();
      if (j == clr_slot) clear_overrun = 1'b1;
      step();
      clear_overrun = 1'b0;
      repeat (7) step();
    end
  endtask

  // monitor: compare accepted results, check stall stability and busy run lengths
  initial begin
    forever begin
      @(negedge clk);
      #2;
      obs = {out_if.out_channel, out_if.out_ave, out_if.out_data, out_if.out_clamped};
      if (!reset) begin
        stalled  = 0;
        busy_run = 0;
      end else begin
        if (busy) busy_run++;
        else if (busy_run > 0) begin
          last_busy_run = busy_run;
          busy_run = 0;
        end
        if (out_if.out_valid) begin
          if (stalled) check_val("stall_stable", 32'(obs), 32'(snap));
          if (out_if.out_ready) begin
            if (exp_q.size() == 0) check_val("unexpected_out", 32'(obs), 32'hFFFF_FFFF);
            else begin
              exp_v = exp_q.pop_front();
              check_val("result", 32'(obs), 32'(exp_v));
            end
            stalled = 0;
          end else begin
            snap = obs;
            stalled = 1;
          end
        end else if (stalled) begin
          check_val("valid_dropped", 32'(out_if.out_valid), 32'd1);
          stalled = 0;
        end
      end
    end
  end

  task automatic check_all_zero(input string phase);
    check_val({phase, "_valid"},   32'(out_if.out_valid),   32'd0);
    check_val({phase, "_data"},    32'(out_if.out_data),    32'd0);
    check_val({phase, "_channel"}, 32'(out_if.out_channel), 32'd0);
    check_val({phase, "_ave"},     32'(out_if.out_ave),     32'd0);
    check_val({phase, "_clamped"}, 32'(out_if.out_clamped), 32'd0);
    check_val({phase, "_overrun"}, 32'(overrun),            32'd0);
    check_val({phase, "_busy"},    32'(busy),               32'd0);
  endtask

  // main sequence
  initial begin
    reset = 1'b0;
    pwm_in = '0;
    ch_enable = '0;
    clear_overrun = 1'b0;
    out_if.out_ready = 1'b1;
    repeat (3) step();
    check_all_zero("reset");
    check_val("reset_state", 32'(dbg_state), 32'd0);
    reset = 1'b1;
    repeat (8) step();

    // all channels mid-scale
    fill_const(8'h80, 8'h80, 8'h80, 8'h80);
    run_block(4'hF, 0, -1);
    // extremes: zero, clamp, tiny, mid
    fill_const(8'h00, 8'hFF, 8'h01, 8'h80);
    run_block(4'hF, 0, -1);
    // alternating ch0 averages to 0x20, others random
    fill_random();
    for (int j = 0; j < 16; j++) begin
      blk_vals[j][0] = (j % 2 == 1) ? 8'h30 : 8'h10;
      blk_vals[j][2] = 8'h01;
    end
    run_block(4'hF, 0, -1);
    // partial enable
    fill_random();
    run_block(4'b1010, 0, -1);
    // nothing enabled: scan only
    fill_random();
    run_block(4'h0, 0, -1);
    check_val("empty_scan_busy_cycles", 32'(last_busy_run), 32'd4);

    // stall across the next completion -> overrun, that block lost
    out_if.out_ready = 1'b0;
    fill_random();
    run_block(4'hF, 0, -1);
    fill_random();
    run_block(4'hF, 1, -1);
    check_val("overrun_set", 32'(overrun), 32'd1);
    check_val("stalled_valid", 32'(out_if.out_valid), 32'd1);
    check_val("stalled_state", 32'(dbg_state), 32'd3);

    // drain, then clear overrun during an empty block
    out_if.out_ready = 1'b1;
    fill_random();
    run_block(4'h0, 0, 0);
    check_val("overrun_cleared", 32'(overrun), 32'd0);
    check_val("drained", 32'(exp_q.size()), 32'd0);

    // clear coincident with a new discard: set wins
    out_if.out_ready = 1'b0;
    fill_random();
    run_block(4'hF, 0, -1);
    fill_random();
    run_block(4'hF, 1, 15);
    check_val("overrun_set_wins", 32'(overrun), 32'd1);
    check_val("valid_before_reset", 32'(out_if.out_valid), 32'd1);

    // reset mid-emission
    step();
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    repeat (3) step();
    reset = 1'b1;
    out_if.out_ready = 1'b1;
    repeat (8) step();

    fill_random();
    run_block(4'hF, 0, -1);
    fill_random();
    run_block(4'b0101, 0, -1);
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step();
    repeat (4) step();
    check_val("final_drained", 32'(exp_q.size()), 32'd0);
    check_val("final_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
